// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry in-order buffer that drains results into the
// register file and merges masked flag updates into the architectural flags.
module alu_writeback #(
  parameter logic [5:0] FLAGS_RESET = 6'b000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_result,
  input  logic [7:0] in_flags,
  input  logic [2:0] in_dest,
  input  logic       in_wr_en,
  input  logic [5:0] in_flag_mask,
  output logic       rf_we,
  output logic [2:0] rf_waddr,
  output logic [7:0] rf_wdata,
  input  logic       rf_ready,
  output logic [7:0] flags_q,
  output logic [1:0] count
);

  typedef struct packed {
    logic [7:0] result;
    logic [5:0] flags;
    logic [2:0] dest;
    logic       wr_en;
    logic [5:0] mask;
  } entry_t;

  entry_t     mem [2];
  entry_t     head;
  logic       wptr, rptr;
  logic [1:0] cnt;
  logic [5:0] flags_r;
  logic       head_vld, accept, retire;

  assign head     = mem[rptr];
  assign head_vld = (cnt != 2'd0);
  // in_ready depends on occupancy only; a full buffer never accepts, even on a retire edge
  assign in_ready = (cnt != 2'd2);
  assign accept   = in_valid && in_ready;
  // entries without a register write retire without waiting for the register file
  assign retire   = head_vld && (!head.wr_en || rf_ready);

  assign rf_we    = head_vld && head.wr_en;
  assign rf_waddr = rf_we ? head.dest   : 3'd0;
  assign rf_wdata = rf_we ? head.result : 8'd0;
  assign flags_q  = {2'b00, flags_r};
  assign count    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 2'd0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      flags_r <= FLAGS_RESET;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wptr] <= '{result: in_result, flags: in_flags[5:0], dest: in_dest,
                       wr_en: in_wr_en, mask: in_flag_mask};
        wptr      <= ~wptr;
      end
      if (retire) begin
        rptr    <= ~rptr;
        flags_r <= (flags_r & ~head.mask) | (head.flags & head.mask);
      end
      cnt <= cnt + {1'b0, accept} - {1'b0, retire};
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: expected writes queued on accept, popped
// when the register-file handshake completes; flags and occupancy checked inline.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic [7:0] in_flags;
  logic [2:0] in_dest;
  logic       in_wr_en;
  logic [5:0] in_flag_mask;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       rf_ready;
  logic [7:0] flags_q;
  logic [1:0] count;

  int checks = 0;
  int failures = 0;
  logic [10:0] sb [$];   // {dest, data}
  logic [5:0]  model_flags;

  alu_writeback dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_dest(in_dest),
    .in_wr_en(in_wr_en), .in_flag_mask(in_flag_mask), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .flags_q(flags_q), .count(count)
  );

  always #5 clk = ~clk;

  // A write seen at the falling edge with rf_ready high completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1 && rf_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rf_write_unexpected got addr=%0d data=%h, scoreboard empty", rf_waddr, rf_wdata);
      end else begin
        logic [10:0] exp;
        exp = sb.pop_front();
        if ({rf_waddr, rf_wdata} !== exp) begin
          failures++;
          $display("FAIL rf_write_order got addr=%0d data=%h expected addr=%0d data=%h",
                   rf_waddr, rf_wdata, exp[10:8], exp[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds one entry on the input until accepted; queues its expected write.
  task automatic push_one(input logic [7:0] r, input logic [2:0] d, input logic w,
                          input logic [7:0] f, input logic [5:0] m);
    logic acc;
    in_valid = 1'b1; in_result = r; in_dest = d; in_wr_en = w;
    in_flags = f; in_flag_mask = m;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      step();
      if (acc) begin
        if (w) sb.push_back({d, r});
        model_flags = (model_flags & ~m) | (f[5:0] & m);
        in_valid = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL push_timeout entry data=%h never accepted", r);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    rf_ready = 1'b1;
    for (int i = 0; i < 20 && count != 2'd0; i++) step();
    checks++;
    if (count !== 2'd0 || sb.size() != 0) begin
      failures++;
      $display("FAIL drain got count=%0d pending=%0d expected 0/0", count, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0; in_dest = '0;
    in_wr_en = 1'b0; in_flag_mask = '0; rf_ready = 1'b1; model_flags = 6'h00;
    #2;
    checks++;
    if ({count, in_ready, rf_we, rf_waddr, rf_wdata, flags_q} !== {2'd0, 1'b1, 1'b0, 3'd0, 8'd0, 8'h00}) begin
      failures++;
      $display("FAIL reset_state got count=%0d rdy=%b we=%b addr=%0d data=%h flags=%h expected 0/1/0/0/00/00",
               count, in_ready, rf_we, rf_waddr, rf_wdata, flags_q);
    end
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    rf_ready = 1'b1;
    push_one(8'h5A, 3'd3, 1'b1, 8'h01, 6'h3F);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 8'h5A}) begin
      failures++;
      $display("FAIL basic_write got we=%b addr=%0d data=%h expected 1/3/5a", rf_we, rf_waddr, rf_wdata);
    end
    step();
    checks++;
    if (flags_q !== 8'h01 || count !== 2'd0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL basic_retire got flags=%h count=%0d we=%b expected 01/0/0", flags_q, count, rf_we);
    end
  endtask

  task automatic test_flag_order();
    rf_ready = 1'b0;
    push_one(8'h10, 3'd5, 1'b1, 8'h04, 6'h04);
    push_one(8'h20, 3'd6, 1'b1, 8'h00, 6'h04);
    rf_ready = 1'b1;
    step();
    checks++;
    if (flags_q !== 8'h05 || count !== 2'd1) begin
      failures++;
      $display("FAIL flag_order_first got flags=%h count=%0d expected 05/1", flags_q, count);
    end
    step();
    checks++;
    if (flags_q !== 8'h01 || count !== 2'd0) begin
      failures++;
      $display("FAIL flag_order_second got flags=%h count=%0d expected 01/0", flags_q, count);
    end
  endtask

  task automatic test_back_to_back();
    rf_ready = 1'b0;
    push_one(8'h11, 3'd1, 1'b1, 8'h00, 6'h00);
    push_one(8'h22, 3'd2, 1'b1, 8'h00, 6'h00);
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_state got count=%0d rdy=%b expected 2/0", count, in_ready);
    end
    in_valid = 1'b1; in_result = 8'h33; in_dest = 3'd4; in_wr_en = 1'b1;
    in_flags = 8'h00; in_flag_mask = 6'h00;
    repeat (3) step();
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0 || rf_waddr !== 3'd1 || rf_wdata !== 8'h11) begin
      failures++;
      $display("FAIL held_full got count=%0d rdy=%b addr=%0d data=%h expected 2/0/1/11",
               count, in_ready, rf_waddr, rf_wdata);
    end
    rf_ready = 1'b1;
    step();
    checks++;
    if (count !== 2'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_retire_no_accept got count=%0d rdy=%b expected 1/1", count, in_ready);
    end
    step();
    sb.push_back({3'd4, 8'h33});
    in_valid = 1'b0;
    checks++;
    if (count !== 2'd1 || rf_waddr !== 3'd4 || rf_wdata !== 8'h33) begin
      failures++;
      $display("FAIL accept_after_full got count=%0d addr=%0d data=%h expected 1/4/33", count, rf_waddr, rf_wdata);
    end
    wait_empty();
  endtask

  task automatic test_no_write();
    rf_ready = 1'b1;
    push_one(8'h00, 3'd0, 1'b0, 8'hFF, 6'h3F);
    step();
    checks++;
    if (flags_q !== 8'h3F) begin
      failures++;
      $display("FAIL flags_set_all got flags=%h expected 3f", flags_q);
    end
    rf_ready = 1'b0;
    push_one(8'hAB, 3'd7, 1'b0, 8'h00, 6'h03);
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 3'd0 || rf_wdata !== 8'd0) begin
      failures++;
      $display("FAIL no_write_strobe got we=%b addr=%0d data=%h expected 0/0/00", rf_we, rf_waddr, rf_wdata);
    end
    step();
    checks++;
    if (flags_q !== 8'h3C || count !== 2'd0) begin
      failures++;
      $display("FAIL no_write_retire got flags=%h count=%0d expected 3c/0", flags_q, count);
    end
  endtask

  task automatic test_mid_reset();
    rf_ready = 1'b0;
    push_one(8'h77, 3'd2, 1'b1, 8'h3F, 6'h3F);
    push_one(8'h88, 3'd3, 1'b1, 8'h00, 6'h3F);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({count, in_ready, rf_we, rf_waddr, rf_wdata, flags_q} !== {2'd0, 1'b1, 1'b0, 3'd0, 8'd0, 8'h00}) begin
      failures++;
      $display("FAIL mid_reset got count=%0d rdy=%b we=%b addr=%0d data=%h flags=%h expected 0/1/0/0/00/00",
               count, in_ready, rf_we, rf_waddr, rf_wdata, flags_q);
    end
    sb.delete();
    model_flags = 6'h00;
    step();
    rst_n = 1'b1;
    push_one(8'h99, 3'd6, 1'b1, 8'h02, 6'h02);
    checks++;
    if (count !== 2'd1 || rf_wdata !== 8'h99) begin
      failures++;
      $display("FAIL first_accept_after_reset got count=%0d data=%h expected 1/99", count, rf_wdata);
    end
    wait_empty();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      rf_ready = 1'($urandom_range(0, 1));
      push_one(8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 6'($urandom));
    end
    wait_empty();
    checks++;
    if (flags_q !== {2'b00, model_flags}) begin
      failures++;
      $display("FAIL random_flags got flags=%h expected %h", flags_q, {2'b00, model_flags});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flag_order();
    test_back_to_back();
    test_no_write();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
- REQ-001 Parameter FLAGS_RESET, default 6'b000000, reset value of architectural flags bits [5:0].
- REQ-002 clk  in  1  single system clock; all state updates on rising edge.
- REQ-003 rst_n  in  1  asynchronous, active-low reset.
- REQ-004 in_valid  in  1  upstream presents an ALU result this cycle.
- REQ-005 in_ready  out  1  block can accept an entry this cycle.
- REQ-006 in_result  in  8  ALU result c.
- REQ-007 in_flags  in  8  ALU flags {2'b0, overflow, parity, sign, zero, aux_carry, carry}.
- REQ-008 in_dest  in  3  destination register index.
- REQ-009 in_wr_en  in  1  1 = result is written to the register file.
- REQ-010 in_flag_mask  in  6  per-bit enable for updating flags [5:0].
- REQ-011 rf_we  out  1  register-file write strobe.
- REQ-012 rf_waddr  out  3  register-file write address.
- REQ-013 rf_wdata  out  8  register-file write data.
- REQ-014 rf_ready  in  1  register file accepts the write this cycle.
- REQ-015 flags_q  out  8  architectural flags register {2'b0, V, P, S, Z, AC, C}.
- REQ-016 count  out  2  buffered entries, 0..2.

Function
- REQ-017 The block SHALL hold a 2-entry in-order FIFO; each entry stores result, flags[5:0], dest, wr_en and mask.
- REQ-018 in_ready SHALL equal (count < 2), driven from registered state only, with no combinational path from in_valid or rf_ready.
- REQ-019 An entry SHALL be accepted on a rising edge where in_valid && in_ready.
- REQ-020 Head entry valid and head.wr_en = 1: rf_we = 1, rf_waddr = head.dest, rf_wdata = head.result; the head SHALL retire only on an edge where rf_ready = 1.
- REQ-021 Head entry valid and head.wr_en = 0: rf_we = 0; the head SHALL retire on the next edge regardless of rf_ready.
- REQ-022 count = 0: rf_we, rf_waddr and rf_wdata SHALL all be 0.
- REQ-023 On retire, flags_q[5:0] SHALL become (flags_q[5:0] & ~mask) | (head.flags & mask); flags_q[7:6] SHALL always be 0; in_flags[7:6] SHALL be ignored.
- REQ-024 Latency: an entry accepted into an empty FIFO at edge N SHALL drive rf_we from the cycle after N; its flag update SHALL be visible the cycle after its retire edge.
- REQ-025 Simultaneous accept and retire SHALL leave count unchanged and preserve order.
- REQ-026 count = 2: in_ready = 0 even if the head retires that cycle; no entry is lost or overwritten.
- REQ-027 Entries SHALL retire in acceptance order, at most one per cycle; FIFO pointers wrap modulo 2.
- REQ-028 Consecutive retires with overlapping masks SHALL apply in order; the later entry wins per bit.
- REQ-029 Outputs SHALL change only after clock edges or reset, never combinationally from the inputs.

Reset
- REQ-030 rst_n = 0 SHALL immediately clear count to 0, discard all entries, force rf_we/rf_waddr/rf_wdata to 0, set flags_q to {2'b0, FLAGS_RESET} and in_ready to 1.
- REQ-031 Reset asserted mid-operation, including during a pending rf write, SHALL drop that write with no partial flag update.
- REQ-032 After rst_n deasserts, the first accept SHALL be honoured on the first rising edge.

Verification
- REQ-033 Empty, rf_ready = 1; push result 8'h5A, dest 3, wr_en 1, flags 6'b000001, mask 6'b111111 -> next cycle rf_we = 1, waddr = 3, wdata = 8'h5A; the cycle after, flags_q = 8'h01, count = 0.
- REQ-034 rf_ready = 0; push 3 entries back-to-back -> in_ready = 0 after the second accept; third entry held by upstream; count = 2; release rf_ready -> writes appear in order, one per cycle.
- REQ-035 flags_q = 8'h3F; push wr_en 0, flags 6'b000000, mask 6'b000011 -> rf_we stays 0; flags_q = 8'h3C after retire, independent of rf_ready.
- REQ-036 Two entries, masks 6'b000100 with flags 6'b000100, then 6'b000100 with flags 6'b000000 -> Z set, then cleared; final flags_q[2] = 0.
- REQ-037 count = 2 with rf_ready = 0; assert rst_n = 0 for one cycle -> count = 0, rf_we = 0, flags_q = 0, in_ready = 1 immediately, before the next edge.
- REQ-038 Full FIFO with a retire edge and in_valid = 1 -> no accept that edge; count goes 2 -> 1; accepted next cycle.
